// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding/hazard unit
package fwd_pkg;
    // History entries carry register addresses at this fixed width; narrower REG_W zero-extends
    localparam int MAX_REG_W = 8;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                 vld;
        logic [MAX_REG_W-1:0] wrt_reg;
        logic                 is_load;
    } hist_entry_t;

    function automatic int imm_sel(input int n_fwd);
        return n_fwd + 1;
    endfunction
endpackage

// File: rtl/fwd_hist_pipe.sv
// fwd_hist_pipe: N_FWD-deep destination history with bubble insertion and flush
module fwd_hist_pipe
    import fwd_pkg::*;
#(
    parameter int N_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    stall,
    input  hist_entry_t             in_entry,
    output hist_entry_t [N_FWD:1]   hist
);
    hist_entry_t [N_FWD:1] hist_q, hist_d;

    // Shift history one stage; a stall injects a bubble, a flush invalidates everything
    always_comb begin
        hist_d = hist_q;
        for (int k = N_FWD; k >= 2; k--) hist_d[k] = hist_q[k-1];
        hist_d[1] = stall ? '0 : in_entry;
        if (flush) for (int k = 1; k <= N_FWD; k++) hist_d[k].vld = 1'b0;
    end

    // History register, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    assign hist = hist_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: multi-stage operand forwarding, load-use stall and event counters
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int REG_W    = 3,
    parameter  int N_FWD    = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int ZERO_REG = 0,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = $clog2(N_FWD + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_reg1,
    input  logic [REG_W-1:0] ex_reg2,
    input  logic             ex_alu_src,
    input  logic             ex_wrt_en,
    input  logic [REG_W-1:0] ex_wrt_reg,
    input  logic             ex_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_mux1,
    output logic [SEL_W-1:0] fwd_mux2,
    output logic [CNT_W-1:0] fwd_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(FWD_RF);
    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(imm_sel(N_FWD));

    hist_entry_t            in_entry;
    hist_entry_t [N_FWD:1]  hist;
    logic [SEL_W-1:0]       sel1, sel2;
    logic                   hz1, hz2, stall_w, fwd_evt;
    logic [CNT_W-1:0]       fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

    // Current EX instruction as a history entry; only valid writers can be forwarded from
    always_comb begin
        in_entry.vld     = ex_valid & ex_wrt_en;
        in_entry.wrt_reg = MAX_REG_W'(ex_wrt_reg);
        in_entry.is_load = ex_is_load;
    end

    fwd_hist_pipe #(.N_FWD(N_FWD)) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .stall    (stall_w),
        .in_entry (in_entry),
        .hist     (hist)
    );

    // Nearest matching stage per operand; walking from the far end lets the nearest overwrite
    always_comb begin
        sel1 = SEL_RF;
        sel2 = SEL_RF;
        hz1  = 1'b0;
        hz2  = 1'b0;
        for (int k = N_FWD; k >= 1; k--) begin
            if (hist[k].vld && hist[k].wrt_reg == MAX_REG_W'(ex_reg1) && !(ZERO_REG != 0 && ex_reg1 == '0)) begin
                sel1 = SEL_W'(k);
                hz1  = hist[k].is_load && (k <= LOAD_LAT);
            end
            if (hist[k].vld && hist[k].wrt_reg == MAX_REG_W'(ex_reg2) && !(ZERO_REG != 0 && ex_reg2 == '0)) begin
                sel2 = SEL_W'(k);
                hz2  = hist[k].is_load && (k <= LOAD_LAT);
            end
        end
    end

    // Load-use stall and mux selects; selects fall back to the register file while stalled or in reset
    always_comb begin
        stall_w  = rst_n && ex_valid && !flush && (hz1 || (!ex_alu_src && hz2));
        fwd_mux1 = (stall_w || !rst_n) ? SEL_RF : sel1;
        fwd_mux2 = (stall_w || !rst_n) ? SEL_RF : ex_alu_src ? SEL_IMM : sel2;
        fwd_evt  = ex_valid && !stall_w && !flush &&
                   (fwd_mux1 != SEL_RF || (fwd_mux2 != SEL_RF && fwd_mux2 != SEL_IMM));
    end

    // Saturating event counters
    always_comb begin
        fwd_cnt_d   = fwd_cnt_q   + CNT_W'(fwd_evt && fwd_cnt_q != '1);
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_w && stall_cnt_q != '1);
    end

    // Counter registers, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_w;
    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding, stalls, flush, reset and counters
module tb_fwd_hazard_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ex_valid = 1'b0, ex_alu_src = 1'b0, ex_wrt_en = 1'b0, ex_is_load = 1'b0, flush = 1'b0;
    logic [2:0] ex_reg1 = '0, ex_reg2 = '0, ex_wrt_reg = '0;
    logic       stall, z_stall;
    logic [1:0] fwd_mux1, fwd_mux2, z_mux1, z_mux2, z_fwd_cnt, z_stall_cnt;
    logic [15:0] fwd_cnt, stall_cnt;
    int checks = 0;
    int errors = 0;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_alu_src(ex_alu_src), .ex_wrt_en(ex_wrt_en), .ex_wrt_reg(ex_wrt_reg),
        .ex_is_load(ex_is_load), .flush(flush), .stall(stall), .fwd_mux1(fwd_mux1),
        .fwd_mux2(fwd_mux2), .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.ZERO_REG(1), .CNT_W(2)) dut_z (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_alu_src(ex_alu_src), .ex_wrt_en(ex_wrt_en), .ex_wrt_reg(ex_wrt_reg),
        .ex_is_load(ex_is_load), .flush(flush), .stall(z_stall), .fwd_mux1(z_mux1),
        .fwd_mux2(z_mux2), .fwd_cnt(z_fwd_cnt), .stall_cnt(z_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] r1, input logic [2:0] r2, input logic src,
                         input logic we, input logic [2:0] wr, input logic ld);
        ex_valid = v; ex_reg1 = r1; ex_reg2 = r2; ex_alu_src = src;
        ex_wrt_en = we; ex_wrt_reg = wr; ex_is_load = ld; flush = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic ld);
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b1, r, ld);
    endtask

    task automatic rd(input logic [2:0] r1, input logic [2:0] r2, input logic src);
        drive(1'b1, r1, r2, src, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        // reset clears history and counters
        wr(3'd1, 1'b0); tick();
        wr(3'd2, 1'b0); tick();
        rst_n = 1'b0;
        rd(3'd1, 3'd2, 1'b0);
        chk("rst_in_stall", stall, 0);
        chk("rst_in_mux1", fwd_mux1, 0);
        chk("rst_in_mux2", fwd_mux2, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rd(3'd1, 3'd2, 1'b0);
        chk("rst_mux1", fwd_mux1, 0);
        chk("rst_mux2", fwd_mux2, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fwd_cnt", fwd_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        tick();
        // back-to-back ALU forwarding on both operands
        wr(3'd3, 1'b0); tick();
        rd(3'd3, 3'd3, 1'b0);
        chk("b2b_mux1", fwd_mux1, 1);
        chk("b2b_mux2", fwd_mux2, 1);
        chk("b2b_stall", stall, 0);
        tick();
        chk("b2b_fwd_cnt", fwd_cnt, 1);
        // distance 2
        wr(3'd5, 1'b0); tick();
        wr(3'd7, 1'b0); tick();
        rd(3'd1, 3'd5, 1'b0);
        chk("d2_mux2", fwd_mux2, 2);
        chk("d2_mux1", fwd_mux1, 0);
        tick();
        // immediate operand masks a load-use on reg2
        wr(3'd5, 1'b1); tick();
        rd(3'd1, 3'd5, 1'b1);
        chk("imm_stall", stall, 0);
        chk("imm_mux2", fwd_mux2, 3);
        tick();
        // load-use: one stall then forward from stage 2
        wr(3'd2, 1'b1); tick();
        rd(3'd2, 3'd4, 1'b0);
        chk("lu_stall", stall, 1);
        chk("lu_mux1", fwd_mux1, 0);
        chk("lu_mux2", fwd_mux2, 0);
        tick();
        chk("lu_stall_after", stall, 0);
        chk("lu_mux1_after", fwd_mux1, 2);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();
        // nearest stage wins
        wr(3'd4, 1'b0); tick();
        wr(3'd4, 1'b0); tick();
        rd(3'd4, 3'd0, 1'b0);
        chk("prio_mux1", fwd_mux1, 1);
        tick();
        // no write enable, no forwarding
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0); tick();
        rd(3'd3, 3'd0, 1'b0);
        chk("nowe_mux1", fwd_mux1, 0);
        tick();
        // hardwired r0 on the ZERO_REG instance only
        wr(3'd0, 1'b0); tick();
        rd(3'd0, 3'd0, 1'b0);
        chk("zero_mux1", z_mux1, 0);
        chk("zero_stall", z_stall, 0);
        chk("nozero_mux1", fwd_mux1, 1);
        tick();
        // flush squashes an in-flight load
        wr(3'd6, 1'b1); tick();
        rd(3'd6, 3'd0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_stall", stall, 0);
        tick();
        rd(3'd6, 3'd0, 1'b0);
        chk("post_flush_stall", stall, 0);
        chk("post_flush_mux1", fwd_mux1, 0);
        tick();
        // five more load-use stalls saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            wr(3'd2, 1'b1); tick();
            rd(3'd2, 3'd0, 1'b0);
            chk("sat_stall", stall, 1);
            tick();
            tick();
        end
        chk("sat_z_stall_cnt", z_stall_cnt, 3);
        chk("sat_stall_cnt", stall_cnt, 6);
        // reset in the middle of a stall
        wr(3'd2, 1'b1); tick();
        rd(3'd2, 3'd0, 1'b0);
        chk("mid_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_after_stall", stall, 0);
        chk("mid_after_mux1", fwd_mux1, 0);
        chk("mid_after_stall_cnt", stall_cnt, 0);
        tick();
        chk("mid_later_stall", stall, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
